// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// On-chip truth-table sweeper for a 2-input combinational gate. It drives
// a_out/b_out through {a,b} = 00, 01, 10, 11 for PASSES sweeps. Each vector
// is held SETTLE cycles before the gate's y_in is sampled against TRUTH[{a,b}].
// The block reports pass/fail, a saturating error count and the first
// failing vector.
//
// Optional feature: define GATE_CHK_STOP_ON_FAIL_EN to end the run on the
// first mismatch instead of completing every sweep.
module gate_truth_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2,
  parameter int         PASSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     state;
  logic [1:0] vec;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;

  logic       mismatch;
  logic       stop_now;
  logic       last_vec;
  logic       finish;
  logic [1:0] vec_next;
  logic [7:0] err_next;

  // Sample-cycle decisions: mismatch, saturating count and end-of-run
  always_comb begin
    mismatch = (y_in != TRUTH[vec]);
    vec_next = vec + 2'd1;
    last_vec = (vec == 2'd3) && (pass_cnt == PASS_LAST);
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF)) begin
      err_next = err_count + 8'd1;
    end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    stop_now = mismatch;
`else
    stop_now = 1'b0;
`endif
    finish = last_vec || stop_now;
  end

  // Sweep FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= '0;
      pass_cnt         <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      a_out            <= 1'b0;
      b_out            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= DRIVE;
            vec              <= '0;
            pass_cnt         <= '0;
            settle_cnt       <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            a_out            <= 1'b0;
            b_out            <= 1'b0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
          end
        end
        DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          settle_cnt <= '0;
          err_count  <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
            a_out <= 1'b0;
            b_out <= 1'b0;
          end else begin
            state <= DRIVE;
            vec   <= vec_next;
            a_out <= vec_next[1];
            b_out <= vec_next[0];
            if (vec == 2'd3) begin
              pass_cnt <= pass_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker
// Two checker instances: one on an AND gate with default settings, and one on
// an XOR gate with SETTLE=3, PASSES=2. Each gate model can flip its output on
// a random set of vectors. Expected results come from a per-vector walk of the
// fault mask.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic       a0, b0, y0, busy0, done0, pass0, ffval0;
  logic [7:0] err0;
  logic [1:0] ffv0;
  logic       a1, b1, y1, busy1, done1, pass1, ffval1;
  logic [7:0] err1;
  logic [1:0] ffv1;

  logic [3:0] mask0 = 4'b0000;
  logic [3:0] mask1 = 4'b0000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Gates under test with injectable per-vector output faults
  assign y0 = (a0 & b0) ^ mask0[{a0, b0}];
  assign y1 = (a1 ^ b1) ^ mask1[{a1, b1}];

  gate_truth_checker dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0)
  );

  gate_truth_checker #(.TRUTH(4'b0110), .SETTLE(3), .PASSES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  // Reference: walk every vector of every sweep; a set mask bit is a mismatch
  task automatic model(input logic [3:0] mask, input int p, input int s,
                       output int errs, output int first, output int dcyc);
    bit stopped;
    stopped = 1'b0;
    errs = 0;
    first = -1;
    dcyc = 1 + 4 * p * (s + 1);
    for (int i = 0; i < 4 * p; i++) begin
      if (!stopped && mask[i % 4]) begin
        errs++;
        if (first < 0) first = i % 4;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        stopped = 1'b1;
        dcyc = 1 + (i + 1) * (s + 1);
`endif
      end
    end
    if (errs > 255) errs = 255;
  endtask

  task automatic obs(input int sel, output logic a, output logic b, output logic bz,
                     output logic dn, output logic ps, output logic [7:0] ec,
                     output logic [1:0] fv, output logic fval);
    if (sel == 0) {a, b, bz, dn, ps, ec, fv, fval} = {a0, b0, busy0, done0, pass0, err0, ffv0, ffval0};
    else          {a, b, bz, dn, ps, ec, fv, fval} = {a1, b1, busy1, done1, pass1, err1, ffv1, ffval1};
  endtask

  // Start is sampled on one edge; afterwards the design is in cycle 1
  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    cyc = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a0, b0, busy0, done0, pass0, err0, ffv0, ffval0} !== 16'h0) begin
      bad++;
      $display("FAIL reset_dut0 got=%h want=0", {a0, b0, busy0, done0, pass0, err0, ffv0, ffval0});
    end
    total++;
    if ({a1, b1, busy1, done1, pass1, err1, ffv1, ffval1} !== 16'h0) begin
      bad++;
      $display("FAIL reset_dut1 got=%h want=0", {a1, b1, busy1, done1, pass1, err1, ffv1, ffval1});
    end
    rst = 1'b0;
  endtask

  task automatic test_random_sweeps(input int sel, input int n);
    logic a, b, bz, dn, ps, fval;
    logic [7:0] ec;
    logic [1:0] fv;
    logic [3:0] mask;
    int s, p, errs, first, dcyc, k;
    s = (sel == 0) ? 2 : 3;
    p = (sel == 0) ? 1 : 2;
    for (int it = 0; it < n; it++) begin
      mask = (it == 0) ? 4'h0 : (it == 1) ? 4'hF : 4'($urandom_range(0, 15));
      if (sel == 0) mask0 = mask; else mask1 = mask;
      model(mask, p, s, errs, first, dcyc);
      pulse_start(sel);
      while (cyc < 200) begin
        obs(sel, a, b, bz, dn, ps, ec, fv, fval);
        if (dn) break;
        k = ((cyc - 1) / (s + 1)) % 4;
        total++;
        if ({bz, a, b} !== {1'b1, 2'(k)}) begin
          bad++;
          $display("FAIL stim dut%0d cyc=%0d got busy,a,b=%b want=%b", sel, cyc, {bz, a, b}, {1'b1, 2'(k)});
        end
        step();
      end
      total++;
      if (cyc !== dcyc) begin
        bad++;
        $display("FAIL done_cycle dut%0d mask=%b got=%0d want=%0d", sel, mask, cyc, dcyc);
      end
      total++;
      if ({bz, ps, ec} !== {1'b0, errs == 0, 8'(errs)}) begin
        bad++;
        $display("FAIL result dut%0d mask=%b got busy,pass,err=%b,%b,%0d want 0,%b,%0d",
                 sel, mask, bz, ps, ec, errs == 0, errs);
      end
      total++;
      if ({fval, fv} !== {first >= 0, (first >= 0) ? 2'(first) : 2'b00}) begin
        bad++;
        $display("FAIL first_fail dut%0d mask=%b got valid,vec=%b,%b want first=%0d", sel, mask, fval, fv, first);
      end
      $display("sweep dut%0d mask=%b done_cyc=%0d err=%0d ffv=%b/%b", sel, mask, cyc, ec, fval, fv);
    end
  endtask

  task automatic test_start_while_busy();
    mask0 = 4'b1000;
    pulse_start(0);
    while (cyc < 5) step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    while (!done0 && cyc < 100) step();
    total++;
    if (cyc !== 13 || err0 !== 8'd1 || ffv0 !== 2'b11 || ffval0 !== 1'b1 || pass0 !== 1'b0) begin
      bad++;
      $display("FAIL busy_start got cyc=%0d err=%0d ffv=%b/%b pass=%b want 13,1,1/11,0", cyc, err0, ffval0, ffv0, pass0);
    end
    $display("busy_start done_cyc=%0d err=%0d", cyc, err0);
    mask0 = 4'b0000;
    pulse_start(0);
    total++;
    if ({done0, busy0, err0, ffval0} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL restart got done,busy,err,ffval=%b,%b,%0d,%b want 0,1,0,0", done0, busy0, err0, ffval0);
    end
    while (!done0 && cyc < 100) step();
    total++;
    if (cyc !== 13 || pass0 !== 1'b1) begin
      bad++;
      $display("FAIL restart_done got cyc=%0d pass=%b want 13,1", cyc, pass0);
    end
    $display("restart done_cyc=%0d pass=%b", cyc, pass0);
  endtask

  task automatic test_rst_mid_sweep();
    mask0 = 4'b0001;
    pulse_start(0);
    while (cyc < 7) step();
    rst = 1'b1;
    start0 = 1'b1;
    step();
    rst = 1'b0;
    start0 = 1'b0;
    total++;
    if ({a0, b0, busy0, done0, pass0, err0, ffv0, ffval0} !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid got=%h want=0", {a0, b0, busy0, done0, pass0, err0, ffv0, ffval0});
    end
    step();
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_start_ignored got busy=%b want 0", busy0);
    end
    mask0 = 4'b0000;
    pulse_start(0);
    while (!done0 && cyc < 100) step();
    total++;
    if (cyc !== 13 || pass0 !== 1'b1 || err0 !== 8'd0) begin
      bad++;
      $display("FAIL rst_rerun got cyc=%0d pass=%b err=%0d want 13,1,0", cyc, pass0, err0);
    end
    $display("rst_mid rerun done_cyc=%0d pass=%b", cyc, pass0);
  endtask

  initial begin
    test_reset();
    test_random_sweeps(0, 8);
    test_random_sweeps(1, 8);
    test_start_while_busy();
    test_rst_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
